// File: rtl/adc_defs.sv
// Shared definitions for the serial ADC read path: FSM encoding and default frame geometry.
package adc_defs;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCsSetup = 2'd1,
    StShift   = 2'd2,
    StQuiet   = 2'd3
  } adc_state_e;

  localparam int unsigned DefClkDiv    = 4;
  localparam int unsigned DefFrameBits = 16;
  localparam int unsigned DefDataBits  = 12;

endpackage

// File: rtl/adc_sclk_gen.sv
// sclk generator for the ADC read master: half-period counter, sclk flop and phase strobes.
module adc_sclk_gen
  import adc_defs::*;
#(
  parameter int unsigned ClkDiv = DefClkDiv
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,        // currently shifting
  input  logic run_i,       // shifting on the next cycle
  output logic sclk_o,
  output logic sample_en_o,
  output logic bit_done_o
);

  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic            wrap;

  assign wrap        = en_i && (cnt_q == CntMax);
  assign sample_en_o = wrap && !sclk_q;
  assign bit_done_o  = wrap && sclk_q;
  assign sclk_o      = sclk_q;

  // Entering the shift phase drops sclk straight away; leaving it parks sclk high.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!run_i) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI read master: one ADC frame per rising edge of start_i, low result bits presented with a strobe.
module adc_spi_reader
  import adc_defs::*;
#(
  parameter int unsigned CLK_DIV    = DefClkDiv,
  parameter int unsigned FRAME_BITS = DefFrameBits,
  parameter int unsigned DATA_BITS  = DefDataBits
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 sdata_i,
  output logic                 cs_n_o,
  output logic                 sclk_o,
  output logic                 busy_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(FRAME_BITS - 1);

  adc_state_e            state_q, state_d;
  logic                  start_q;
  logic [CntW-1:0]       wait_q, wait_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  dv_q, dv_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  start_edge;
  logic                  sample_en, bit_done;

  assign start_edge = start_i & ~start_q;

  adc_sclk_gen #(
    .ClkDiv(CLK_DIV)
  ) u_sclk_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (state_q == StShift),
    .run_i      (state_d == StShift),
    .sclk_o     (sclk_o),
    .sample_en_o(sample_en),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    case (state_q)
      StIdle: begin
        bit_d = '0;
        if (start_edge) state_d = StCsSetup;
      end
      StCsSetup: begin
        if (wait_q == CntMax) state_d = StShift;
        else                  wait_d  = wait_q + 1'b1;
      end
      StShift: begin
        if (sample_en) begin
          shift_d    = shift_q << 1;
          shift_d[0] = sdata_i;
        end
        // The last sample lands half a bit before the final bit_done, so shift_q is complete here.
        if (bit_done) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == LastBit) begin
            state_d = StQuiet;
            data_d  = shift_q[DATA_BITS-1:0];
            dv_d    = 1'b1;
          end
        end
      end
      StQuiet: begin
        if (wait_q == CntMax) state_d = StIdle;
        else                  wait_d  = wait_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
    cs_n_d = !((state_d == StCsSetup) || (state_d == StShift));
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      wait_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
    end
  end

  assign cs_n_o       = cs_n_q;
  assign busy_o       = busy_q;
  assign data_o       = data_q;
  assign data_valid_o = dv_q;

endmodule
